game_round_timer: RTL
=====================

# game_round_timer

Countdown timer for game rounds, placed directly downstream of the `clock_divider` block. It consumes the four divided-clock taps as plain data signals and selects one. It brings the selected tap into the system `clk` domain and detects its rising edges. It then decrements a loadable round counter once per tick, with start/pause control and a single-cycle expiry pulse for the game FSM.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.

Ports:
- `clk`, in, 1: system clock. All logic uses its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `clk_div2`, `clk_div4`, `clk_div8`, `clk_div16`, in, 1 each: divider taps, treated as asynchronous data.
- `rate_sel`, in, 2: tap select. 0 selects div2, 1 div4, 2 div8, 3 div16.
- `start`, in, 1: load `load_val` and begin counting. Level-sampled each cycle.
- `pause`, in, 1: hold the count while high.
- `load_val`, in, `WIDTH`: round length in ticks.
- `count`, out, `WIDTH`: current remaining ticks.
- `running`, out, 1: high in RUN.
- `tick`, out, 1: one-cycle pulse per selected tap rising edge.
- `expired`, out, 1: one-cycle pulse when the count reaches 0.

## Operation
- Tap path: mux by `rate_sel`, then sync flops `s1`, `s2`, then history flop `s3`. `tick` = `s2 & ~s3`.
- States: IDLE, RUN, PAUSED, DONE.
- Priority in every state: `start` > `pause` > `tick`.
- IDLE:
  - `start` with `load_val != 0`: `count <= load_val`, go to RUN.
  - `start` with `load_val == 0`: go to DONE and pulse `expired`.
- RUN:
  - `pause`: go to PAUSED. A `tick` in the same cycle is dropped.
  - `tick` with `count > 1`: `count <= count - 1`.
  - `tick` with `count == 1`: `count <= 0`, pulse `expired`, go to DONE.
- PAUSED:
  - `count` holds and ticks are ignored.
  - `pause` low: return to RUN.
- DONE: `count` holds 0.
- `start` in RUN, PAUSED or DONE restarts the round: reload `load_val` and go to RUN (zero rule as in IDLE).
- The count never wraps below 0.
- Changing `rate_sel` mid-round can cause at most one spurious or missed tick. This is accepted and needs no protection.

## Timing
- Reset values: state IDLE, `s1`/`s2`/`s3` = 0, `count` = 0, `running` = 0, `tick` = 0, `expired` = 0.
- Reset asserted mid-round aborts immediately; no `expired` pulse is produced.
- Tap latency: the first `clk` edge that samples the tap high is edge N. `tick` is high for exactly the one cycle following edge N+1.
- `count`, `running` and `expired` are registered. They update on the clock edge where `tick` or `start` is sampled high.
- `expired` is high for exactly one cycle and never two in a row.
- `start` held high keeps reloading, so the count does not decrement while `start` is high.

## Configuration
- `GAME_TIMER_AUTORELOAD_EN` defined: on expiry in RUN, `count <= load_val` and the state stays RUN. `expired` still pulses. If `load_val == 0` at that moment, go to DONE.
- `GAME_TIMER_AUTORELOAD_EN` undefined: expiry always goes to DONE, as described above.

## Structure
- Package `game_timer_pkg`:
  - State enum (IDLE, RUN, PAUSED, DONE).
  - `RATE_DIV2`..`RATE_DIV16` constants (0..3).
- Sub-module `tap_edge_sync`:
  - Ports: `clk`, `reset`, async in, `tick` out.
  - Contents: 2-flop synchronizer plus rising-edge detect.
- Top level: mux, FSM, counter.

## Test plan
- Reset, `rate_sel` = 0, `load_val` = 3, `start` pulsed, free-running taps → three `tick`s bring `count` 3→2→1→0, `expired` pulses once, state is DONE, `running` = 0.
- `rate_sel` = 3, one `clk_div16` rising edge → `tick` high 1 cycle, 2 cycles after the first sampling edge. No tick on the tap's falling edge.
- `load_val` = 5 in RUN, `pause` held across 2 ticks, then released → `count` holds at 5 while paused and resumes decrementing after release. `pause` and `tick` in the same cycle → no decrement.
- `load_val` = 0 with `start` → DONE next cycle, `expired` = 1 for one cycle, `count` = 0.
- `reset` asserted at `count` = 2 mid-RUN → all outputs 0 asynchronously, no `expired` pulse. Restart with `start`, `load_val` = 4 → `count` = 4.
- `GAME_TIMER_AUTORELOAD_EN` defined, `load_val` = 2 → `expired` pulses every 2 ticks, `count` sequence 2,1,2,1, `running` stays 1.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game round timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StDone
  } state_e;

  localparam logic [1:0] RATE_DIV2  = 2'd0;
  localparam logic [1:0] RATE_DIV4  = 2'd1;
  localparam logic [1:0] RATE_DIV8  = 2'd2;
  localparam logic [1:0] RATE_DIV16 = 2'd3;

endpackage

// File: rtl/tap_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by rising-edge detection.
module tap_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign tick = r_s2 & ~r_s3;

endmodule

// File: rtl/game_round_timer.sv
// Round countdown timer: selects a divider tap, syncs it to clk and decrements once per tick.
// Optional build macro GAME_TIMER_AUTORELOAD_EN reloads the count on expiry instead of stopping.
module game_round_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_div2,
  input  logic             clk_div4,
  input  logic             clk_div8,
  input  logic             clk_div16,
  input  logic [1:0]       rate_sel,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick,
  output logic             expired
);

  logic             w_tap;
  logic             w_tick;
  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic             r_running;
  logic             r_expired;
  logic             w_expired_d;

  always_comb begin
    unique case (rate_sel)
      RATE_DIV2:  w_tap = clk_div2;
      RATE_DIV4:  w_tap = clk_div4;
      RATE_DIV8:  w_tap = clk_div8;
      RATE_DIV16: w_tap = clk_div16;
    endcase
  end

  tap_edge_sync u_tap_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (w_tap),
    .tick     (w_tick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_expired_d = 1'b0;
    if (start) begin
      if (load_val != '0) begin
        w_count_d = load_val;
        w_state_d = StRun;
      end else begin
        w_count_d   = '0;
        w_state_d   = StDone;
        // Held start with a zero load must not produce back-to-back pulses.
        w_expired_d = ~r_expired;
      end
    end else begin
      unique case (r_state)
        StIdle: ;
        StRun: begin
          if (pause) begin
            w_state_d = StPaused;
          end else if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
              w_count_d = r_count - WIDTH'(1);
            end else begin
              w_expired_d = 1'b1;
`ifdef GAME_TIMER_AUTORELOAD_EN
              if (load_val != '0) begin
                w_count_d = load_val;
              end else begin
                w_count_d = '0;
                w_state_d = StDone;
              end
`else
              w_count_d = '0;
              w_state_d = StDone;
`endif
            end
          end
        end
        StPaused: begin
          if (!pause) w_state_d = StRun;
        end
        StDone: w_count_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_running <= (w_state_d == StRun);
      r_expired <= w_expired_d;
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign tick    = w_tick;
  assign expired = r_expired;

endmodule
